// File: rtl/gt_sweep_pkg.sv
// Shared types and defaults for the greater-than comparator sweep checker.
package gt_sweep_pkg;
  localparam int DEF_W      = 2;
  localparam int DEF_SETTLE = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } sweep_state_e;
endpackage

// File: rtl/gt_settle_timer.sv
// Settle countdown: load arms it, expire fires on the last of SETTLE run cycles.
module gt_settle_timer
  import gt_sweep_pkg::*;
#(
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic run,
  output logic expire
);
  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (load)             cnt <= 4'(SETTLE - 1);
    else if (run && cnt != '0) cnt <= cnt - 4'd1;
  end

  assign expire = run && (cnt == '0);
endmodule

// File: rtl/gt_sweep_checker.sv
// Exhaustively sweeps {A,B} into an external A>B comparator and scores f_in.
module gt_sweep_checker
  import gt_sweep_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic [W-1:0]   a_out,
  output logic [W-1:0]   b_out,
  input  logic           f_in,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [2*W:0]   err_count,
  output logic [2*W-1:0] fail_vec,
  output logic           fail_valid
);
  localparam int IW = 2 * W;
  localparam logic [IW-1:0] IDX_MAX = '1;

  sweep_state_e  state_q, state_d;
  logic [IW-1:0] idx_q;
  logic          tmr_load, tmr_expire, mismatch, last_vec;

  gt_settle_timer #(.SETTLE(SETTLE)) u_settle (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tmr_load),
    .run    (state_q == DRIVE),
    .expire (tmr_expire)
  );

  assign a_out    = idx_q[IW-1:W];
  assign b_out    = idx_q[W-1:0];
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign last_vec = (idx_q == IDX_MAX);
  assign mismatch = (state_q == SAMPLE) && (f_in != (a_out > b_out));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    case (state_q)
      IDLE:   if (start) begin state_d = DRIVE; tmr_load = 1'b1; end
      DRIVE:  if (tmr_expire) state_d = SAMPLE;
      SAMPLE: begin
        if (last_vec) state_d = DONE;
        else begin state_d = DRIVE; tmr_load = 1'b1; end
      end
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      err_count  <= '0;
      fail_vec   <= '0;
      fail_valid <= 1'b0;
      pass       <= 1'b0;
    end else if (state_q == IDLE && start) begin
      idx_q      <= '0;
      err_count  <= '0;
      fail_vec   <= '0;
      fail_valid <= 1'b0;
      pass       <= 1'b0;
    end else begin
      if (state_q == SAMPLE && !last_vec) idx_q <= idx_q + 1'b1;
      if (mismatch) err_count <= err_count + 1'b1;
      if (mismatch && !fail_valid) begin
        fail_vec   <= idx_q;
        fail_valid <= 1'b1;
      end
      // Verdict is registered on entry to DONE so it is valid alongside the done pulse.
      if (state_q == SAMPLE && last_vec) pass <= (err_count == '0) && !mismatch;
    end
  end
endmodule

// File: tb/tb_gt_sweep_checker.sv
// Randomized sweeps of gt_sweep_checker against a per-vector scoring model.
module tb_gt_sweep_checker;
  import gt_sweep_pkg::*;

  localparam int W      = 2;
  localparam int SETTLE = 2;
  localparam int NV     = 1 << (2 * W);
  localparam int LAT    = NV * (SETTLE + 1);

  logic           clk = 1'b0;
  logic           rst_n, start, f_in, busy, done, pass, fail_valid;
  logic [W-1:0]   a_out, b_out;
  logic [2*W:0]   err_count;
  logic [2*W-1:0] fail_vec;
  int             mode;
  logic [NV-1:0]  rnd_tab;
  int             total = 0;
  int             bad   = 0;

  always #5 clk = ~clk;

  gt_sweep_checker #(.W(W), .SETTLE(SETTLE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a_out      (a_out),
    .b_out      (b_out),
    .f_in       (f_in),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .fail_vec   (fail_vec),
    .fail_valid (fail_valid)
  );

  // Comparator under test: 0 good, 1 stuck-0, 2 stuck-1, 3 inverted, else random table.
  function automatic logic comp_f(int m, logic [NV-1:0] tab, int v);
    int a, b;
    a = v >> W;
    b = v % (1 << W);
    case (m)
      0:       return a > b;
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return !(a > b);
      default: return tab[v];
    endcase
  endfunction

  assign f_in = comp_f(mode, rnd_tab, int'({a_out, b_out}));

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Starts on the next edge, waits for done; repulse>=0 re-pulses start at that vector.
  task automatic run_sweep(int m, int repulse, string tag);
    int  cyc, e_err, e_first;
    bit  found, pulsed;
    e_err = 0; e_first = 0; found = 0;
    for (int v = 0; v < NV; v++)
      if (comp_f(m, rnd_tab, v) != ((v >> W) > (v % (1 << W)))) begin
        e_err++;
        if (!found) begin found = 1; e_first = v; end
      end
    mode = m;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk({tag, ".busy_go"}, busy, 1);
    chk({tag, ".clr_err"}, err_count, 0);
    chk({tag, ".clr_fv"}, fail_valid, 0);
    chk({tag, ".clr_pass"}, pass, 0);
    chk({tag, ".vec0"}, {a_out, b_out}, 0);
    cyc = 0; pulsed = 0;
    while (cyc < LAT + 20 && !done) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (repulse >= 0 && !pulsed && int'({a_out, b_out}) == repulse) begin
        start = 1'b1; pulsed = 1;
      end else start = 1'b0;
    end
    start = 1'b0;
    chk({tag, ".latency"}, cyc, LAT);
    chk({tag, ".done"}, done, 1);
    chk({tag, ".pass"}, pass, (e_err == 0));
    chk({tag, ".err"}, err_count, e_err);
    chk({tag, ".fv"}, fail_valid, found);
    chk({tag, ".fvec"}, fail_vec, e_first);
    @(negedge clk);
    chk({tag, ".done_1cy"}, done, 0);
    chk({tag, ".idle"}, busy, 0);
    chk({tag, ".hold_vec"}, {a_out, b_out}, NV - 1);
    chk({tag, ".hold_err"}, err_count, e_err);
  endtask

  initial begin
    int cyc;
    bit hit;
    rst_n = 1'b0; start = 1'b0; mode = 0; rnd_tab = '0;
    #1;
    chk("rst.busy", busy, 0);
    chk("rst.vec", {a_out, b_out}, 0);
    chk("rst.err", err_count, 0);
    chk("rst.pass", pass, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rel.no_start", busy, 0);

    run_sweep(0, -1, "good");
    run_sweep(1, -1, "stuck0");
    run_sweep(2, -1, "stuck1");
    run_sweep(3, -1, "invert");
    run_sweep(0, 5, "repulse");
    run_sweep(1, -1, "stuck0b");
    run_sweep(0, -1, "good_after");

    // start held high across DONE restarts on the first IDLE cycle
    mode = 0;
    @(negedge clk); start = 1'b1;
    cyc = 0;
    while (cyc < LAT + 20 && !done) begin @(posedge clk); cyc++; @(negedge clk); end
    chk("hold.done", done, 1);
    @(negedge clk);
    chk("hold.idle", busy, 0);
    @(negedge clk);
    chk("hold.restart", busy, 1);
    chk("hold.vec0", {a_out, b_out}, 0);
    start = 1'b0;
    cyc = 0;
    while (cyc < LAT + 20 && !done) begin @(posedge clk); cyc++; @(negedge clk); end
    chk("hold.latency", cyc, LAT);

    // reset in the middle of a failing sweep
    mode = 1;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if (busy && int'({a_out, b_out}) == 7) hit = 1;
    end
    chk("mid.reach7", hit, 1);
    chk("mid.err_pre", err_count, 1);
    rst_n = 1'b0;
    #1;
    chk("mid.busy", busy, 0);
    chk("mid.done", done, 0);
    chk("mid.vec", {a_out, b_out}, 0);
    chk("mid.err", err_count, 0);
    chk("mid.fvec", fail_vec, 0);
    chk("mid.fv", fail_valid, 0);
    chk("mid.pass", pass, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mid.quiet", {busy, done}, 0);
    end
    run_sweep(0, -1, "after_rst");

    // random comparators, random gaps, random re-pulse points
    for (int k = 0; k < 6; k++) begin
      rnd_tab = NV'($urandom);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run_sweep(4, ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, NV - 1)) : -1, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gt_sweep_checker.md
GT_SWEEP_CHECKER -- requirements
Module: gt_sweep_checker

Interface
REQ-001 The block SHALL have one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-002 Parameter W, default 2, SHALL set the width of each comparator operand.
REQ-003 Parameter SETTLE, default 2, SHALL set the cycles each vector is held before sampling; valid range is 1..15.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  request a full sweep; sampled only in IDLE.
REQ-007 a_out  out  W  operand A driven to the comparator under test.
REQ-008 b_out  out  W  operand B driven to the comparator under test.
REQ-009 f_in  in  1  comparator result under test; 1 means A>B.
REQ-010 busy  out  1  high from sweep acceptance until DONE is left.
REQ-011 done  out  1  one-cycle pulse at sweep completion.
REQ-012 pass  out  1  1 when the last completed sweep had zero mismatches.
REQ-013 err_count  out  2W+1  mismatches counted in the current or last sweep.
REQ-014 fail_vec  out  2W  {A,B} of the first mismatching vector.
REQ-015 fail_valid  out  1  fail_vec holds a captured vector.

Function
REQ-016 The state machine SHALL have four states: IDLE, DRIVE, SAMPLE and DONE.
REQ-017 In IDLE with start=1, the block SHALL go to DRIVE with vector index 0, and SHALL clear err_count, fail_vec, fail_valid and pass at that edge.
REQ-018 The vector index SHALL be 2W bits; {a_out,b_out} = index, with A in the MSBs, ascending 0 to 2^(2W)-1.
REQ-019 DRIVE SHALL hold the vector for exactly SETTLE cycles, counted by a settle timer, then go to SAMPLE.
REQ-020 SAMPLE SHALL last one cycle and compare f_in against the unsigned result a_out>b_out.
REQ-021 On a mismatch in SAMPLE, err_count SHALL increment by 1, and fail_vec/fail_valid SHALL capture the vector only if fail_valid=0.
REQ-022 After SAMPLE, the block SHALL go to DONE if the index is at its maximum; otherwise it SHALL increment the index and return to DRIVE.
REQ-023 The index SHALL NOT wrap around during a sweep.
REQ-024 err_count SHALL NOT saturate; its 2W+1 bits hold the maximum count, 2^(2W).
REQ-025 DONE SHALL last one cycle: done=1, pass set to (err_count==0, including the final sample), then IDLE.
REQ-026 Sweep latency from the start edge to the done pulse SHALL be 2^(2W)*(SETTLE+1) cycles; done is high in the cycle after that.
REQ-027 busy SHALL be 1 in DRIVE, SAMPLE and DONE, and 0 in IDLE.
REQ-028 start SHALL be ignored while busy=1; no queuing.
REQ-029 start held high through DONE SHALL begin a new sweep on the first IDLE cycle.
REQ-030 a_out/b_out SHALL hold the last vector in IDLE after a sweep.
REQ-031 Results (pass, err_count, fail_vec, fail_valid) SHALL hold until the next accepted start.

Reset
REQ-032 rst_n low SHALL immediately force IDLE, index 0, settle timer 0, a_out=0, b_out=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0 and fail_valid=0.
REQ-033 Reset mid-sweep SHALL abandon the sweep with no done pulse, and the next start SHALL restart at vector 0.
REQ-034 Reset release SHALL be taken synchronously by the first clk edge with rst_n high; no sweep starts without start.

Structure
REQ-035 The state encoding (IDLE=0, DRIVE=1, SAMPLE=2, DONE=3) and the default W and SETTLE values SHALL reside in a shared package, gt_sweep_pkg.
REQ-036 The settle countdown SHALL be a sub-module, gt_settle_timer, with load/expire handshaking.
REQ-037 The expected-value compare SHALL be inline combinational logic.

Verification
REQ-038 W=2, SETTLE=2, correct comparator, start pulse -> done at cycle 49 after the start edge, pass=1, err_count=0, fail_valid=0.
REQ-039 f_in stuck at 0 -> err_count=6, pass=0, fail_vec=4'b0100, fail_valid=1.
REQ-040 f_in stuck at 1 -> err_count=10, pass=0, fail_vec=4'b0000.
REQ-041 f_in inverted (~(A>B)) -> err_count=16, pass=0, fail_vec=4'b0000; no counter overflow.
REQ-042 start re-pulsed at vector 5 -> ignored, sweep completes normally; a second start after DONE -> results cleared, new sweep begins at vector 0.
REQ-043 rst_n asserted at vector 7 -> all outputs 0 immediately, no done pulse; a later start -> full 49-cycle sweep from vector 0.
